// File: rtl/axi_lite_gpio_pkg.sv
// Shared definitions for the multi-channel AXI4-Lite GPIO: register map, response codes and
// the address decoder used by both the read and the write path.
package axi_lite_gpio_pkg;

  localparam int unsigned CH_STRIDE = 32'h10;

  localparam logic [3:0] OFF_DOUT = 4'h0;
  localparam logic [3:0] OFF_DIR  = 4'h4;
  localparam logic [3:0] OFF_DIN  = 4'h8;
  localparam logic [3:0] OFF_RSVD = 4'hC;
  localparam logic [3:0] OFF_IER  = 4'h0;
  localparam logic [3:0] OFF_ISR  = 4'h4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {RegDout, RegDir, RegDin, RegRsvd, RegIer, RegIsr} reg_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] ch;
    reg_e       sel;
  } access_t;

  // Channel blocks first, global block right after the last channel; anything else is invalid.
  function automatic access_t decode_addr(input logic [31:0] addr, input int unsigned num_ch);
    access_t     acc;
    logic [31:0] blk;
    logic [3:0]  off;
    acc = '{valid: 1'b0, ch: 3'd0, sel: RegRsvd};
    blk = addr / CH_STRIDE;
    off = 4'(addr % CH_STRIDE);
    if (blk < num_ch) begin
      acc.ch    = blk[2:0];
      acc.valid = 1'b1;
      unique case (off)
        OFF_DOUT: acc.sel = RegDout;
        OFF_DIR:  acc.sel = RegDir;
        OFF_DIN:  acc.sel = RegDin;
        OFF_RSVD: acc.sel = RegRsvd;
        default:  acc.valid = 1'b0;
      endcase
    end else if (blk == num_ch) begin
      unique case (off)
        OFF_IER: begin acc.sel = RegIer; acc.valid = 1'b1; end
        OFF_ISR: begin acc.sel = RegIsr; acc.valid = 1'b1; end
        default: acc.valid = 1'b0;
      endcase
    end
    return acc;
  endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// Two-flop pad synchroniser for one GPIO channel plus a previous-sample register that flags
// any bit of the synchronised value changing in either direction.
module gpio_in_sync #(
  parameter int unsigned GPIO_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [GPIO_W-1:0] pad_i,
  output logic [GPIO_W-1:0] din_o,
  output logic [GPIO_W-1:0] change_o
);

  logic [GPIO_W-1:0] sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= pad_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign din_o    = sync2_q;
  assign change_o = sync2_q ^ prev_q;

endmodule

// File: rtl/axi_lite_gpio_mc.sv
// AXI4-Lite multi-channel GPIO with per-bit direction, synchronised inputs and byte strobes.
// Define GPIO_IRQ_EN to build the IER/ISR edge-interrupt logic; otherwise irq is tied low.
module axi_lite_gpio_mc
  import axi_lite_gpio_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 7,
  parameter int unsigned NUM_CH             = 4,
  parameter int unsigned GPIO_W             = 32
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  input  logic [NUM_CH*GPIO_W-1:0]        gpio_i,
  output logic [NUM_CH*GPIO_W-1:0]        gpio_o,
  output logic [NUM_CH*GPIO_W-1:0]        gpio_t,
  output logic                            irq
);

  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;

  logic                          ready_en_q;
  logic                          aw_held_q, w_held_q;
  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q;
  logic [DW-1:0]                 w_data_q, wmask, rd_data;
  logic [DW/8-1:0]               w_strb_q;
  logic                          bvalid_q, rvalid_q;
  logic [1:0]                    bresp_q, rresp_q;
  logic [DW-1:0]                 rdata_q;
  logic [NUM_CH-1:0][GPIO_W-1:0] dout_q, dout_d, dir_q, dir_d, din;
  logic [NUM_CH-1:0]             chg_any, ier_rd, isr_rd;
  logic                          aw_hs, w_hs, ar_hs, commit;
  access_t                       wr_acc, rd_acc;
  logic                          unused_prot;

  assign unused_prot = ^{s00_axi_awprot, s00_axi_arprot};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [GPIO_W-1:0] change;
    gpio_in_sync #(.GPIO_W(GPIO_W)) u_sync (
      .clk_i    (s00_axi_aclk),
      .rst_i    (s00_axi_areset),
      .pad_i    (gpio_i[c*GPIO_W +: GPIO_W]),
      .din_o    (din[c]),
      .change_o (change)
    );
    assign chg_any[c] = |change;
  end

  assign gpio_o = dout_q;
  assign gpio_t = ~dir_q;

  // One outstanding write: both ready lines stay low from capture until the B handshake.
  assign s00_axi_awready = ready_en_q & ~aw_held_q & ~bvalid_q;
  assign s00_axi_wready  = ready_en_q & ~w_held_q & ~bvalid_q;
  assign s00_axi_arready = ready_en_q & ~rvalid_q;
  assign aw_hs  = s00_axi_awvalid & s00_axi_awready;
  assign w_hs   = s00_axi_wvalid & s00_axi_wready;
  assign ar_hs  = s00_axi_arvalid & s00_axi_arready;
  assign commit = aw_held_q & w_held_q;
  assign wr_acc = decode_addr(32'(aw_addr_q), NUM_CH);
  assign rd_acc = decode_addr(32'(s00_axi_araddr), NUM_CH);

  function automatic logic [GPIO_W-1:0] apply_strb(input logic [GPIO_W-1:0] old,
                                                   input logic [DW-1:0] data,
                                                   input logic [DW-1:0] mask);
    return GPIO_W'((DW'(old) & ~mask) | (data & mask));
  endfunction

  always_comb begin
    wmask = '0;
    for (int unsigned k = 0; k < DW/8; k++) wmask[k*8 +: 8] = {8{w_strb_q[k]}};
  end

  always_comb begin
    dout_d = dout_q;
    dir_d  = dir_q;
    if (commit && wr_acc.valid) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (wr_acc.ch == 3'(c)) begin
          if (wr_acc.sel == RegDout) dout_d[c] = apply_strb(dout_q[c], w_data_q, wmask);
          if (wr_acc.sel == RegDir)  dir_d[c]  = apply_strb(dir_q[c], w_data_q, wmask);
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_acc.valid) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (rd_acc.ch == 3'(c)) begin
          unique case (rd_acc.sel)
            RegDout: rd_data = DW'(dout_q[c]);
            RegDir:  rd_data = DW'(dir_q[c]);
            RegDin:  rd_data = DW'(din[c]);
            default: ;
          endcase
        end
      end
      if (rd_acc.sel == RegIer) rd_data = DW'(ier_rd);
      if (rd_acc.sel == RegIsr) rd_data = DW'(isr_rd);
    end
  end

`ifdef GPIO_IRQ_EN
  logic [NUM_CH-1:0] ier_q, ier_d, isr_q, isr_d, isr_clr;
  logic              irq_q;

  // A new edge in the same cycle as a W1C keeps the status bit set.
  always_comb begin
    ier_d   = ier_q;
    isr_clr = '0;
    if (commit && wr_acc.valid && w_strb_q[0]) begin
      if (wr_acc.sel == RegIer) ier_d   = w_data_q[NUM_CH-1:0];
      if (wr_acc.sel == RegIsr) isr_clr = w_data_q[NUM_CH-1:0];
    end
    isr_d = (isr_q & ~isr_clr) | chg_any;
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      ier_q <= '0;
      isr_q <= '0;
      irq_q <= 1'b0;
    end else begin
      ier_q <= ier_d;
      isr_q <= isr_d;
      irq_q <= |(isr_q & ier_q);
    end
  end

  assign ier_rd = ier_q;
  assign isr_rd = isr_q;
  assign irq    = irq_q;
`else
  logic unused_chg;
  assign unused_chg = ^chg_any;
  assign ier_rd     = '0;
  assign isr_rd     = '0;
  assign irq        = 1'b0;
`endif

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      ready_en_q <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      dout_q     <= '0;
      dir_q      <= '0;
    end else begin
      ready_en_q <= 1'b1;
      dout_q     <= dout_d;
      dir_q      <= dir_d;
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        aw_addr_q <= s00_axi_awaddr;
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        w_data_q <= s00_axi_wdata;
        w_strb_q <= s00_axi_wstrb;
      end
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= wr_acc.valid ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_q && s00_axi_bready) begin
        bvalid_q <= 1'b0;
      end
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= rd_acc.valid ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid_q && s00_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign s00_axi_bvalid = bvalid_q;
  assign s00_axi_bresp  = bresp_q;
  assign s00_axi_rvalid = rvalid_q;
  assign s00_axi_rresp  = rresp_q;
  assign s00_axi_rdata  = rdata_q;

endmodule
